// File: rtl/lcd_bus_ctrl.sv
// lcd_bus_ctrl: 8080-style LCD panel bus master. It buffers commands in a 4-deep FIFO
// and also sequences the panel reset at power-on and when a re-reset is requested.
module lcd_bus_ctrl #(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1,
    parameter int RST_CYC    = 10,
    parameter int WAKE_CYC   = 20
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_rd,
    input  logic        i_cmd_rs,
    input  logic [15:0] i_cmd_data,
    input  logic        i_hw_reset_req,
    output logic        o_rd_valid,
    output logic [15:0] o_rd_data,
    output logic        o_init_done,
    output logic        o_busy,
    output logic        o_lcd_reset_n,
    output logic        o_lcd_cs_n,
    output logic        o_lcd_rs,
    output logic        o_lcd_write_n,
    output logic        o_lcd_read_n,
    output logic [15:0] o_lcd_data_out,
    output logic        o_lcd_data_oe,
    input  logic [15:0] i_lcd_data_in
);
    localparam int CW = 16;

    typedef enum logic [2:0] {RST_ASSERT, RST_WAIT, IDLE, SETUP, STROBE, HOLD} state_t;

    state_t        r_state, w_nstate;
    logic [CW-1:0] r_cnt, w_len;
    logic [17:0]   r_mem [4];
    logic [17:0]   w_head;
    logic [1:0]    r_wp, r_rp;
    logic [2:0]    r_count;
    logic          r_rd, r_rst_pend;
    logic          w_last, w_pop, w_flush, w_push, w_restart, w_active, w_empty, w_rd_done;

    assign w_head      = r_mem[r_rp];
    assign w_last      = r_cnt == '0;
    assign w_empty     = r_count == 3'd0;
    assign o_cmd_ready = r_count != 3'd4;
    assign o_busy      = r_state != IDLE || !w_empty;
    assign w_push      = i_cmd_valid && o_cmd_ready && !w_flush;
    assign w_active    = w_nstate inside {SETUP, STROBE, HOLD};
    assign w_rd_done   = r_state == STROBE && w_last && r_rd;

    always_comb begin
        w_nstate  = r_state;
        w_pop     = 1'b0;
        w_flush   = 1'b0;
        w_restart = 1'b0;
        case (r_state)
            RST_ASSERT, RST_WAIT: begin
                w_restart = i_hw_reset_req;
                if (i_hw_reset_req) w_nstate = RST_ASSERT;
                else if (w_last) w_nstate = r_state == RST_ASSERT ? RST_WAIT : IDLE;
            end
            IDLE: begin
                w_flush  = i_hw_reset_req;
                w_pop    = !i_hw_reset_req && !w_empty;
                w_nstate = i_hw_reset_req ? RST_ASSERT : w_empty ? IDLE : SETUP;
            end
            SETUP:  w_nstate = w_last ? STROBE : SETUP;
            STROBE: w_nstate = w_last ? HOLD : STROBE;
            HOLD: if (w_last) begin
                // a latched re-reset wins over the next queued command
                w_flush  = r_rst_pend || i_hw_reset_req;
                w_pop    = !w_flush && !w_empty;
                w_nstate = w_flush ? RST_ASSERT : w_empty ? IDLE : SETUP;
            end
            default: w_nstate = RST_ASSERT;
        endcase
        w_len = w_nstate == RST_ASSERT ? CW'(RST_CYC - 1) :
                w_nstate == RST_WAIT   ? CW'(WAKE_CYC - 1) :
                w_nstate == SETUP      ? CW'(SETUP_CYC - 1) :
                w_nstate == STROBE     ? CW'(STROBE_CYC - 1) :
                w_nstate == HOLD       ? CW'(HOLD_CYC - 1) : '0;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= RST_ASSERT;
            r_cnt   <= CW'(RST_CYC - 1);
        end else begin
            r_state <= w_nstate;
            r_cnt   <= (w_nstate != r_state || r_state == IDLE || w_restart) ? w_len : r_cnt - CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wp] <= {i_cmd_rd, i_cmd_rs, i_cmd_data};
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            r_wp    <= r_wp + 2'(w_push);
            r_rp    <= r_rp + 2'(w_pop);
            r_count <= r_count + 3'(w_push) - 3'(w_pop);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rd           <= 1'b0;
            r_rst_pend     <= 1'b0;
            o_lcd_reset_n  <= 1'b0;
            o_lcd_cs_n     <= 1'b1;
            o_lcd_write_n  <= 1'b1;
            o_lcd_read_n   <= 1'b1;
            o_lcd_rs       <= 1'b0;
            o_lcd_data_out <= '0;
            o_lcd_data_oe  <= 1'b0;
            o_rd_data      <= '0;
            o_rd_valid     <= 1'b0;
            o_init_done    <= 1'b0;
        end else begin
            r_rst_pend    <= !w_flush && (r_rst_pend || (i_hw_reset_req && r_state inside {SETUP, STROBE, HOLD}));
            o_lcd_reset_n <= w_nstate != RST_ASSERT;
            o_lcd_cs_n    <= !w_active;
            o_lcd_write_n <= !(w_nstate == STROBE && !r_rd);
            o_lcd_read_n  <= !(w_nstate == STROBE && r_rd);
            o_init_done   <= w_active || w_nstate == IDLE;
            o_rd_valid    <= w_rd_done;
            if (w_rd_done) o_rd_data <= i_lcd_data_in;
            if (w_pop) begin
                r_rd           <= w_head[17];
                o_lcd_rs       <= w_head[16];
                o_lcd_data_out <= w_head[15:0];
                o_lcd_data_oe  <= !w_head[17];
            end else if (!w_active) begin
                o_lcd_data_oe <= 1'b0;
            end
        end
    end
endmodule
